round_ctrl: RTL and testbench



---
 rtl/round_ctrl.sv | 159 +++++++++++++++
 tb/tb_round_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/round_ctrl.sv
// round_ctrl: sequences one tug-of-war round. Holds the go light off for a
// pseudo-random delay, detects the first push (including jumped lights),
// reports it with a one-cycle winrnd, then waits for release + cool-down.
module round_ctrl #(
    parameter int          TICK_DIV  = 1000,
    parameter int          DLY_MIN   = 16,
    parameter int          DLY_RND_W = 6,
    parameter int          LIGHT_TO  = 255,
    parameter int          COOL      = 32,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pbl,
    input  logic       pbr,
    input  logic       game_over,
    output logic       leds_on,
    output logic       winrnd,
    output logic       right,
    output logic       tie,
    output logic [2:0] state_dbg
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_LIT     = 3'd1,
        S_REPORT  = 3'd2,
        S_RELEASE = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    state_t          state, next_state;
    logic [2:0]      l_sync, r_sync;   // [0]=s1, [1]=s2, [2]=s3 (edge flop)
    logic            rise_l, rise_r, rise_any;
    logic [PW-1:0]   pre_cnt;
    logic            tick;
    logic [7:0]      lfsr;
    logic [CW-1:0]   dly_cnt, to_cnt, cool_cnt, dly_load;
    logic            cap_leds;

    assign rise_l    = l_sync[1] & ~l_sync[2];
    assign rise_r    = r_sync[1] & ~r_sync[2];
    assign rise_any  = rise_l | rise_r;
    assign tick      = (pre_cnt == PW'(TICK_DIV - 1));
    assign dly_load  = CW'(DLY_MIN) + CW'(lfsr[DLY_RND_W-1:0]);
    assign state_dbg = state;

    // Button synchronisers plus the edge-detect flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_sync <= '0;
            r_sync <= '0;
        end else begin
            l_sync <= {l_sync[1:0], pbl};
            r_sync <= {r_sync[1:0], pbr};
        end
    end

    // Free-running tick prescaler, independent of FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pre_cnt <= '0;
        else if (tick)   pre_cnt <= '0;
        else             pre_cnt <= pre_cnt + 1'b1;
    end

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, steps every clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_WAIT;
        else        state <= next_state;
    end

    // Next-state and light/pulse outputs
    always_comb begin
        next_state = state;
        leds_on    = 1'b0;
        winrnd     = 1'b0;
        case (state)
            S_WAIT: begin
                if (rise_any)                     next_state = S_REPORT;
                else if (tick && dly_cnt == CW'(1)) next_state = S_LIT;
            end
            S_LIT: begin
                leds_on = 1'b1;
                // A push in the same cycle as the timeout wins over the timeout
                if (rise_any || (tick && to_cnt == CW'(1))) next_state = S_REPORT;
            end
            S_REPORT: begin
                winrnd     = 1'b1;
                leds_on    = cap_leds;
                next_state = S_RELEASE;
            end
            S_RELEASE: begin
                if (!l_sync[1] && !r_sync[1] && tick && cool_cnt == CW'(1))
                    next_state = game_over ? S_OVER : S_WAIT;
            end
            S_OVER:  next_state = S_OVER;
            default: next_state = S_WAIT;
        endcase
    end

    // Round counters and the captured result qualifiers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_cnt  <= CW'(DLY_MIN) + CW'(LFSR_SEED[DLY_RND_W-1:0]);
            to_cnt   <= '0;
            cool_cnt <= '0;
            cap_leds <= 1'b0;
            right    <= 1'b0;
            tie      <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (rise_any) begin
                        cap_leds <= 1'b0;
                        right    <= rise_r & ~rise_l;
                        tie      <= rise_l & rise_r;
                    end else if (tick) begin
                        if (dly_cnt == CW'(1)) to_cnt  <= CW'(LIGHT_TO);
                        else                   dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                S_LIT: begin
                    if (rise_any) begin
                        cap_leds <= 1'b1;
                        right    <= rise_r & ~rise_l;
                        tie      <= rise_l & rise_r;
                    end else if (tick) begin
                        if (to_cnt == CW'(1)) begin
                            cap_leds <= 1'b1;
                            right    <= 1'b0;
                            tie      <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
                    end
                end
                S_REPORT: cool_cnt <= CW'(COOL);
                S_RELEASE: begin
                    // Holding either button keeps the cool-down reloaded
                    if (l_sync[1] || r_sync[1]) cool_cnt <= CW'(COOL);
                    else if (tick) begin
                        if (cool_cnt == CW'(1)) dly_cnt  <= dly_load;
                        else                    cool_cnt <= cool_cnt - 1'b1;
                    end
                end
                S_OVER: ;
                default: dly_cnt <= dly_load;
            endcase
        end
    end
endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with a fast tick (TICK_DIV=4).
module tb_round_ctrl;
    localparam int TD = 4, DMIN = 2, DRW = 2, LTO = 8, CL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pbl = 1'b0, pbr = 1'b0, game_over = 1'b0;
    logic       leds_on, winrnd, right, tie;
    logic [2:0] state_dbg;
    int         tests = 0, fails = 0;

    round_ctrl #(.TICK_DIV(TD), .DLY_MIN(DMIN), .DLY_RND_W(DRW), .LIGHT_TO(LTO),
                 .COOL(CL), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .pbl(pbl), .pbr(pbr), .game_over(game_over),
        .leds_on(leds_on), .winrnd(winrnd), .right(right), .tie(tie),
        .state_dbg(state_dbg));

    always #5 clk = ~clk;

    // Cycles until state_dbg==target, or -1 if budget runs out
    task automatic wait_state(input logic [2:0] target, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (state_dbg == target) begin n = i; break; end
        end
    endtask

    // Cycles until winrnd, or -1; also reports whether the light was seen on before it
    task automatic wait_win(input int budget, output int n, output bit saw_led);
        n = -1; saw_led = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (winrnd) begin n = i; break; end
            if (leds_on) saw_led = 1'b1;
        end
    endtask

    task automatic do_reset();
        pbl = 0; pbr = 0; game_over = 0;
        @(negedge clk); rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst_n = 0; #1;
        tests++;
        if ({leds_on, winrnd, right, tie, state_dbg} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs got %b want 0000000", {leds_on, winrnd, right, tie, state_dbg});
        end
    endtask

    task automatic test_light_and_timeout();
        int n; bit s;
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_state(3'd1, 100, n);
        tests++;
        if (n !== 12) begin fails++; $display("FAIL light_delay got %0d cycles want 12", n); end
        wait_win(100, n, s);
        tests++;
        if (n !== LTO * TD || tie !== 1'b1 || right !== 1'b0 || leds_on !== 1'b1) begin
            fails++;
            $display("FAIL timeout_win got n=%0d tie=%b right=%b leds=%b want n=32 tie=1 right=0 leds=1",
                     n, tie, right, leds_on);
        end
        @(posedge clk); #1;
        tests++;
        if (winrnd !== 1'b0 || state_dbg !== 3'd3) begin
            fails++; $display("FAIL win_one_cycle got winrnd=%b state=%0d want 0/3", winrnd, state_dbg);
        end
    endtask

    task automatic test_push_lit();
        int n; bit s;
        wait_state(3'd1, 200, n);
        tests++;
        if (n < 0) begin fails++; $display("FAIL reach_lit got timeout want LIT"); end
        pbr = 1;
        wait_win(10, n, s);
        tests++;
        if (n < 3 || n > 4 || right !== 1'b1 || tie !== 1'b0 || leds_on !== 1'b1) begin
            fails++;
            $display("FAIL push_lit got n=%0d right=%b tie=%b leds=%b want n=3..4 right=1 tie=0 leds=1",
                     n, right, tie, leds_on);
        end
        repeat (10 - n) @(posedge clk);
        #1 pbr = 0;
        tests++;
        if (state_dbg !== 3'd3) begin fails++; $display("FAIL release_hold got state %0d want 3", state_dbg); end
        wait_state(3'd0, 40, n);
        tests++;
        if (n < 15 || n > 18) begin fails++; $display("FAIL cooldown got %0d cycles want 15..18", n); end
    endtask

    task automatic test_jump();
        int n; bit s;
        pbl = 1;
        wait_win(10, n, s);
        tests++;
        if (n < 0 || s || leds_on !== 1'b0 || right !== 1'b0 || tie !== 1'b0) begin
            fails++;
            $display("FAIL jump got n=%0d saw_led=%b leds=%b right=%b tie=%b want leds=0 right=0 tie=0",
                     n, s, leds_on, right, tie);
        end
        @(posedge clk); #1 pbl = 0;
        wait_state(3'd0, 40, n);
    endtask

    task automatic test_tie();
        int n; bit s;
        wait_state(3'd1, 200, n);
        pbl = 1; pbr = 1;
        wait_win(10, n, s);
        tests++;
        if (n < 0 || tie !== 1'b1 || right !== 1'b0 || leds_on !== 1'b1) begin
            fails++;
            $display("FAIL tie_lit got n=%0d tie=%b right=%b leds=%b want tie=1 right=0 leds=1",
                     n, tie, right, leds_on);
        end
        @(posedge clk); #1 pbl = 0; pbr = 0;
        wait_state(3'd0, 40, n);
        pbl = 1; pbr = 1;
        wait_win(10, n, s);
        tests++;
        if (n < 0 || tie !== 1'b1 || right !== 1'b0 || leds_on !== 1'b0) begin
            fails++;
            $display("FAIL tie_wait got n=%0d tie=%b right=%b leds=%b want tie=1 right=0 leds=0",
                     n, tie, right, leds_on);
        end
        @(posedge clk); #1 pbl = 0; pbr = 0;
        wait_state(3'd0, 40, n);
    endtask

    task automatic test_hold_and_over();
        int n, wins; bit s, bad;
        wait_state(3'd1, 200, n);
        pbr = 1;
        wait_win(10, n, s);
        wins = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (winrnd) wins++;
            if (state_dbg !== 3'd3) bad = 1;
        end
        tests++;
        if (wins !== 0 || bad) begin
            fails++; $display("FAIL hold_no_rewin got wins=%0d left_release=%b want 0/0", wins, bad);
        end
        game_over = 1;
        pbr = 0;
        wait_state(3'd4, 40, n);
        tests++;
        if (n < 15 || n > 18) begin fails++; $display("FAIL enter_over got %0d cycles want 15..18", n); end
        wins = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            pbl = (i >= 5 && i < 15); pbr = (i >= 20 && i < 30);
            @(posedge clk); #1;
            if (winrnd) wins++;
            if (leds_on || state_dbg !== 3'd4 || right !== 1'b1 || tie !== 1'b0) bad = 1;
        end
        tests++;
        if (wins !== 0 || bad) begin
            fails++; $display("FAIL over_hold got wins=%0d bad=%b want 0/0", wins, bad);
        end
    endtask

    task automatic test_reset_mid_round();
        int n; bit s;
        do_reset();
        wait_state(3'd1, 100, n);
        pbr = 1;
        wait_win(10, n, s);
        @(posedge clk); #1 pbr = 0;
        wait_state(3'd1, 200, n);
        pbr = 1;
        @(posedge clk);
        @(negedge clk); rst_n = 0; #1;
        tests++;
        if ({leds_on, winrnd, right, tie, state_dbg} !== 7'b0) begin
            fails++;
            $display("FAIL async_reset got %b want 0000000", {leds_on, winrnd, right, tie, state_dbg});
        end
        pbr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        wait_state(3'd1, 100, n);
        tests++;
        if (n !== 12) begin fails++; $display("FAIL relight_after_reset got %0d cycles want 12", n); end
    endtask

    initial begin
        test_reset();
        test_light_and_timeout();
        test_push_lit();
        test_jump();
        test_tie();
        test_hold_and_over();
        test_reset_mid_round();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
